// File: rtl/p_div_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle,
// valid/ready input, one-cycle out_valid pulse, outputs held between results.
module p_div_seq #(
    parameter int DIVIDEND_W = 96,
    parameter int DIVISOR_W  = 48,
    parameter int CNT_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_1,
    input  logic [DIVISOR_W-1:0]  in_2,
    output logic                  out_valid,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int RW = DIVISOR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  remo_q, remo_d;
    logic                  dbz_q, dbz_d;

    logic [RW-1:0]         rem_sh;
    logic                  take;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVIDEND_W-1:0] dvd_nxt;
    logic                  last;

    // The stored remainder is always below the divisor, so only the shifted
    // value needs the extra bit; the low bits of the difference are exact.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[DIVIDEND_W-1]};
        take    = (rem_sh >= {1'b0, dvs_q});
        rem_nxt = take ? (rem_sh[DIVISOR_W-1:0] - dvs_q)
                       : rem_sh[DIVISOR_W-1:0];
        dvd_nxt = {dvd_q[DIVIDEND_W-2:0], take};
        last    = (cnt_q == LAST_CNT);
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        remo_d    = remo_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dvd_d   = in_1;
                    dvs_d   = in_2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                dvd_d = dvd_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    quo_d   = dvd_nxt;
                    remo_d  = rem_nxt;
                    dbz_d   = (dvs_q == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                if (in_valid) begin
                    dvd_d   = in_1;
                    dvs_d   = in_2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_p_div_seq.sv
// Directed bench for p_div_seq: latency, results, divide-by-zero,
// busy-input rejection, back-to-back acceptance and reset mid-operation.
module tb_p_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_1;
    logic [47:0] in_2;
    logic        out_valid;
    logic [95:0] quotient;
    logic [47:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    p_div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_1       (in_1),
        .in_2       (in_2),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until out_valid, starting at cycle 'start'; -1 on timeout.
    task automatic wait_valid(input int start, output int n);
        n = start;
        while (!out_valid && n < start + 400) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic accept(input logic [95:0] a, input logic [47:0] b);
        in_1     = a;
        in_2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_1     = '0;
        in_2     = '0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp += 5;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        if (quotient !== 96'd0) begin
            n_err++;
            $display("FAIL reset_quotient got %0d want 0", quotient);
        end
        if (remainder !== 48'd0) begin
            n_err++;
            $display("FAIL reset_remainder got %0d want 0", remainder);
        end
        if (div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dbz got %b want 0", div_by_zero);
        end
    endtask

    task automatic test_divide_basic();
        int n;
        accept(96'd1000, 48'd7);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_in_ready got %b want 0", in_ready);
        end
        wait_valid(1, n);
        n_cmp += 4;
        if (n !== 97) begin
            n_err++;
            $display("FAIL basic_latency got %0d want 97", n);
        end
        if (quotient !== 96'd142) begin
            n_err++;
            $display("FAIL basic_quotient got %0d want 142", quotient);
        end
        if (remainder !== 48'd6) begin
            n_err++;
            $display("FAIL basic_remainder got %0d want 6", remainder);
        end
        if (div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL basic_dbz got %b want 0", div_by_zero);
        end
        tick();
        n_cmp += 2;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pulse_width got %b want 0", out_valid);
        end
        if (quotient !== 96'd142) begin
            n_err++;
            $display("FAIL basic_hold got %0d want 142", quotient);
        end
    endtask

    task automatic test_max_values();
        int n;
        logic [95:0] q_exp;
        q_exp = (96'd1 << 48) + 96'd1;
        accept({96{1'b1}}, {48{1'b1}});
        wait_valid(1, n);
        n_cmp += 3;
        if (n !== 97) begin
            n_err++;
            $display("FAIL max_latency got %0d want 97", n);
        end
        if (quotient !== q_exp) begin
            n_err++;
            $display("FAIL max_quotient got %h want %h", quotient, q_exp);
        end
        if (remainder !== 48'd0) begin
            n_err++;
            $display("FAIL max_remainder got %h want 0", remainder);
        end
        tick();
        accept(96'h80, 48'd16);
        wait_valid(1, n);
        n_cmp += 3;
        if (n !== 97) begin
            n_err++;
            $display("FAIL prod_latency got %0d want 97", n);
        end
        if (quotient !== 96'd8) begin
            n_err++;
            $display("FAIL prod_quotient got %0d want 8", quotient);
        end
        if (remainder !== 48'd0) begin
            n_err++;
            $display("FAIL prod_remainder got %0d want 0", remainder);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int n;
        accept(96'h1234, 48'd0);
        wait_valid(1, n);
        n_cmp += 4;
        if (n !== 97) begin
            n_err++;
            $display("FAIL dz_latency got %0d want 97", n);
        end
        if (quotient !== {96{1'b1}}) begin
            n_err++;
            $display("FAIL dz_quotient got %h want all ones", quotient);
        end
        if (remainder !== 48'h1234) begin
            n_err++;
            $display("FAIL dz_remainder got %h want 1234", remainder);
        end
        if (div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL dz_flag got %b want 1", div_by_zero);
        end
        tick();
        n_cmp++;
        if (div_by_zero !== 1'b1) begin
            n_err++;
            $display("FAIL dz_hold got %b want 1", div_by_zero);
        end
    endtask

    task automatic test_busy_ignored();
        int n;
        int pulses;
        accept(96'd100, 48'd3);
        for (int i = 1; i < 40; i++) tick();
        in_1     = 96'd50;
        in_2     = 48'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(41, n);
        n_cmp += 4;
        if (n !== 97) begin
            n_err++;
            $display("FAIL busy_latency got %0d want 97", n);
        end
        if (quotient !== 96'd33) begin
            n_err++;
            $display("FAIL busy_quotient got %0d want 33", quotient);
        end
        if (remainder !== 48'd1) begin
            n_err++;
            $display("FAIL busy_remainder got %0d want 1", remainder);
        end
        if (div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL busy_dbz got %b want 0", div_by_zero);
        end
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        n_cmp += 2;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL busy_extra_pulse got %0d want 0", pulses);
        end
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_idle_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        in_1     = 96'd100;
        in_2     = 48'd3;
        in_valid = 1'b1;
        tick();
        in_1 = 96'd81;
        in_2 = 48'd9;
        wait_valid(1, n);
        n_cmp += 4;
        if (n !== 97) begin
            n_err++;
            $display("FAIL b2b_first_latency got %0d want 97", n);
        end
        if (quotient !== 96'd33 || remainder !== 48'd1) begin
            n_err++;
            $display("FAIL b2b_first got %0d,%0d want 33,1",
                     quotient, remainder);
        end
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        if (in_ready !== 1'b0 || quotient !== 96'd33) begin
            n_err++;
            $display("FAIL b2b_hold got rdy=%b q=%0d want 0,33",
                     in_ready, quotient);
        end
        wait_valid(98, n);
        n_cmp += 2;
        if (n !== 194) begin
            n_err++;
            $display("FAIL b2b_second_latency got %0d want 194", n);
        end
        if (quotient !== 96'd9 || remainder !== 48'd0) begin
            n_err++;
            $display("FAIL b2b_second got %0d,%0d want 9,0",
                     quotient, remainder);
        end
        tick();
    endtask

    task automatic test_reset_mid_calc();
        int n;
        int pulses;
        pulses = 0;
        accept(96'd1000, 48'd7);
        for (int i = 1; i < 50; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp += 4;
        if (quotient !== 96'd0 || remainder !== 48'd0) begin
            n_err++;
            $display("FAIL rmid_outputs got %0d,%0d want 0,0",
                     quotient, remainder);
        end
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_in_ready got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_out_valid got %b want 0", out_valid);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL rmid_pulse got %0d want 0", pulses);
        end
        accept(96'd10, 48'd3);
        wait_valid(1, n);
        n_cmp += 2;
        if (n !== 97) begin
            n_err++;
            $display("FAIL rmid_new_latency got %0d want 97", n);
        end
        if (quotient !== 96'd3 || remainder !== 48'd1) begin
            n_err++;
            $display("FAIL rmid_new got %0d,%0d want 3,1",
                     quotient, remainder);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_divide_basic();
        test_max_values();
        test_div_zero();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/p_div_seq.md
Name: p_div_seq

Overview:
- Sequential radix-2 restoring divider. It is the inverse companion of the team's pipelined multiplier (96-bit product = (in_1+in_2)*in_3).
- Takes a 96-bit dividend, such as a multiplier product, and a 48-bit divisor, and returns a 96-bit quotient and a 48-bit remainder.
- Produces one quotient bit per cycle, with a valid/ready input handshake and a one-cycle out_valid pulse.
- Used to recover operands and check multiplier results on-chip.

Parameters:
- DIVIDEND_W, 96, dividend and quotient width.
- DIVISOR_W, 48, divisor and remainder width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > DIVIDEND_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  dividend/divisor present this cycle.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_1  in  DIVIDEND_W  dividend.
- in_2  in  DIVISOR_W  divisor.
- out_valid  out  1  one-cycle pulse; quotient/remainder/div_by_zero valid.
- quotient  out  DIVIDEND_W  floor(in_1 / in_2).
- remainder  out  DIVISOR_W  in_1 mod in_2.
- div_by_zero  out  1  accepted divisor was 0.

Behaviour:
- Reset is synchronous, active-high, on the clk rising edge.
  - Reset takes priority over everything.
  - After reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_1 into the dividend shift register and in_2 into the divisor register; clear the partial remainder (DIVISOR_W+1 bits); counter=0; go to CALC.
  - CALC: in_ready=0. Each cycle:
    - rem' = {rem[DIVISOR_W-1:0], dividend MSB}; shift dividend left by 1.
    - If rem' >= divisor: rem = rem' - divisor and shift 1 into the quotient LSB; else rem = rem' and shift 0.
    - counter+1. After the DIVIDEND_W-th iteration go to DONE.
  - DONE: out_valid=1 for exactly this cycle; quotient, remainder and div_by_zero are driven with the final values. in_ready=1.
    - If in_valid in DONE: accept the new pair, go to CALC.
    - Otherwise go to IDLE.
- Acceptance occurs only when in_valid && in_ready at a rising edge. in_valid while in_ready=0 is ignored; the operands are not queued.
- Latency: for an acceptance edge at cycle N, out_valid is high in cycle N+DIVIDEND_W+1, i.e. 97 cycles for defaults. Latency is fixed regardless of operand values.
- Throughput: one result per DIVIDEND_W+1 cycles with back-to-back acceptance in DONE.
- Output hold: quotient, remainder and div_by_zero hold their last values until the next DONE. They are not cleared when out_valid falls.
- Divisor 0: no special path; the fixed latency is kept.
  - The algorithm naturally yields quotient = all ones and remainder = in_1[DIVISOR_W-1:0].
  - div_by_zero=1 in that DONE cycle and is held with the outputs.
- Widths: the partial remainder is DIVISOR_W+1 bits so the compare/subtract never overflows. The final remainder is always < divisor when divisor != 0.
- Reset mid-CALC: the operation is abandoned and there is no out_valid pulse. Outputs return to the reset values on the next cycle.
- The block is unsigned only.

Test Plan:
- Divide 1000 by 7: in_1=1000, in_2=7, in_valid at cycle 0 -> out_valid only at cycle 97; quotient=142, remainder=6, div_by_zero=0.
- Maximum values: in_1=2^96-1, in_2=2^48-1 -> quotient=2^48+1, remainder=0. Also in_1=0x80 (the multiplier product (3+5)*16), in_2=16 -> quotient=8, remainder=0.
- Divide by zero: in_1=0x1234, in_2=0 -> at cycle 97, quotient=all ones, remainder=0x1234, div_by_zero=1.
- Busy input ignored: accept 100/3. Pulse in_valid with 50/5 at cycle 40 -> single out_valid at 97, quotient=33, remainder=1. No second out_valid appears.
- Back-to-back: hold in_valid high with 100/3 and then 81/9 -> the second pair is accepted in the DONE cycle. out_valid at 97 (33,1) and at 194 (9,0); outputs hold between the pulses.
- Reset mid-CALC: accept 1000/7, assert rst at cycle 50 for 1 cycle -> no out_valid. From the next cycle, quotient=remainder=0 and in_ready=1. A new 10/3 accepted afterwards yields 3,1 after 97 cycles.
